// File: rtl/pipe_stage_elastic_if.sv
// Handshake and payload bundle for one elastic pipeline stage: the upstream
// (in_*) and downstream (out_*) sides of the stage.
interface pipe_stage_elastic_if #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [ILEN-1:0] in_inst;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_pc4;
  logic            out_valid;
  logic            out_ready;
  logic [ILEN-1:0] out_inst;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pc4;

  // Environment side: feeds upstream entries and the downstream ready.
  modport master (
    output in_valid, in_inst, in_pc, in_pc4, out_ready,
    input  in_ready, out_valid, out_inst, out_pc, out_pc4
  );

  // Stage side.
  modport slave (
    input  in_valid, in_inst, in_pc, in_pc4, out_ready,
    output in_ready, out_valid, out_inst, out_pc, out_pc4
  );
endinterface

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage carrying inst/PC/PC+4 with valid/ready flow control,
// optional two-entry skid buffer, synchronous flush and a saturating stall counter.
module pipe_stage_elastic #(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter bit              SKID     = 1'b1,
  parameter logic [ILEN-1:0] NOP_INST = ILEN'(32'h0000_0013),
  parameter int              CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  pipe_stage_elastic_if.slave ps,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Encoding is {skid_valid, main_valid}.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

  logic [1:0]      state_q, state_d;
  logic [ILEN-1:0] main_inst_q, main_inst_d;
  logic [XLEN-1:0] main_pc_q, main_pc_d;
  logic [XLEN-1:0] main_pc4_q, main_pc4_d;
  logic [ILEN-1:0] skid_inst_q, skid_inst_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic [XLEN-1:0] skid_pc4_q, skid_pc4_d;
  logic            in_ready_q, in_ready_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic            acc;
  logic            dlv;

  assign ps.out_valid = state_q[0];
  assign ps.out_inst  = main_inst_q;
  assign ps.out_pc    = main_pc_q;
  assign ps.out_pc4   = main_pc4_q;
  assign stall_cnt    = stall_q;

  // Without a skid slot the stage can only take a new entry when the held one leaves.
  assign ps.in_ready = SKID ? in_ready_q : (!state_q[0] || ps.out_ready);

  assign acc = ps.in_valid && ps.in_ready;
  assign dlv = ps.out_valid && ps.out_ready;

  always_comb begin
    state_d     = state_q;
    main_inst_d = main_inst_q;
    main_pc_d   = main_pc_q;
    main_pc4_d  = main_pc4_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;
    skid_pc4_d  = skid_pc4_q;
    in_ready_d  = in_ready_q;
    stall_d     = stall_q;

    if (ps.out_valid && !ps.out_ready && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end

    if (flush) begin
      state_d     = ST_EMPTY;
      main_inst_d = NOP_INST;
      main_pc_d   = '0;
      main_pc4_d  = '0;
      in_ready_d  = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d     = ST_ONE;
            main_inst_d = ps.in_inst;
            main_pc_d   = ps.in_pc;
            main_pc4_d  = ps.in_pc4;
          end
        end
        ST_ONE: begin
          if (acc && dlv) begin
            main_inst_d = ps.in_inst;
            main_pc_d   = ps.in_pc;
            main_pc4_d  = ps.in_pc4;
          end else if (acc) begin
            // Only reachable with SKID=1: the combinational ready blocks this case otherwise.
            state_d     = ST_FULL;
            skid_inst_d = ps.in_inst;
            skid_pc_d   = ps.in_pc;
            skid_pc4_d  = ps.in_pc4;
            in_ready_d  = 1'b0;
          end else if (dlv) begin
            state_d     = ST_EMPTY;
            main_inst_d = NOP_INST;
            main_pc_d   = '0;
            main_pc4_d  = '0;
          end
        end
        ST_FULL: begin
          if (dlv) begin
            state_d     = ST_ONE;
            main_inst_d = skid_inst_q;
            main_pc_d   = skid_pc_q;
            main_pc4_d  = skid_pc4_q;
            in_ready_d  = 1'b1;
          end
        end
        default: begin
          state_d     = ST_EMPTY;
          main_inst_d = NOP_INST;
          main_pc_d   = '0;
          main_pc4_d  = '0;
          in_ready_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_EMPTY;
      main_inst_q <= NOP_INST;
      main_pc_q   <= '0;
      main_pc4_q  <= '0;
      skid_inst_q <= '0;
      skid_pc_q   <= '0;
      skid_pc4_q  <= '0;
      in_ready_q  <= 1'b1;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      main_inst_q <= main_inst_d;
      main_pc_q   <= main_pc_d;
      main_pc4_q  <= main_pc4_d;
      skid_inst_q <= skid_inst_d;
      skid_pc_q   <= skid_pc_d;
      skid_pc4_q  <= skid_pc4_d;
      in_ready_q  <= in_ready_d;
      stall_q     <= stall_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: a SKID=1/CNT_W=4 and a SKID=0 instance share stimulus,
// each checked against a queue model of in-flight entries.
module tb_pipe_stage_elastic;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
  } entry_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_inst = '0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_pc4 = '0;
  logic [3:0]  sc1;
  logic [15:0] sc0;

  int n_checks = 0;
  int n_pass = 0;

  // Index 1: SKID=1 instance, index 0: SKID=0 instance.
  entry_t      exp_q[2][$];
  int unsigned stall_m[2];

  pipe_stage_elastic_if #(.XLEN(32), .ILEN(32)) if1 ();
  pipe_stage_elastic_if #(.XLEN(32), .ILEN(32)) if0 ();

  assign if1.in_valid  = in_valid;
  assign if1.in_inst   = in_inst;
  assign if1.in_pc     = in_pc;
  assign if1.in_pc4    = in_pc4;
  assign if1.out_ready = out_ready;
  assign if0.in_valid  = in_valid;
  assign if0.in_inst   = in_inst;
  assign if0.in_pc     = in_pc;
  assign if0.in_pc4    = in_pc4;
  assign if0.out_ready = out_ready;

  pipe_stage_elastic #(
    .XLEN(32), .ILEN(32), .SKID(1'b1), .NOP_INST(NOP), .CNT_W(4)
  ) u_s1 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .ps(if1.slave), .stall_cnt(sc1)
  );

  pipe_stage_elastic #(
    .XLEN(32), .ILEN(32), .SKID(1'b0), .NOP_INST(NOP), .CNT_W(16)
  ) u_s0 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .ps(if0.slave), .stall_cnt(sc0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut_skid%0d: got %h expected %h (t=%0t)", name, id, act, exp, $time);
  endtask

  task automatic monitor(input int id, input bit skid, input int unsigned smax,
                         input logic ov, input logic ir, input logic [31:0] inst,
                         input logic [31:0] pc, input logic [31:0] pc4, input logic [15:0] sc);
    entry_t f;
    int     sz;
    if (!reset_n) begin
      exp_q[id].delete();
      stall_m[id] = 0;
      chk("rst_out_valid", id, 32'(ov), 32'd0);
      chk("rst_in_ready", id, 32'(ir), 32'd1);
      chk("rst_out_inst", id, inst, NOP);
      chk("rst_out_pc", id, pc, 32'd0);
      chk("rst_out_pc4", id, pc4, 32'd0);
      chk("rst_stall_cnt", id, 32'(sc), 32'd0);
      return;
    end
    sz = exp_q[id].size();
    chk("stall_cnt", id, 32'(sc), stall_m[id]);
    chk("out_valid", id, 32'(ov), 32'(sz > 0));
    chk("in_ready", id, 32'(ir), skid ? 32'(sz < 2) : 32'((sz == 0) || out_ready));
    if (sz > 0) begin
      f = exp_q[id][0];
      chk("out_inst", id, inst, f.inst);
      chk("out_pc", id, pc, f.pc);
      chk("out_pc4", id, pc4, f.pc4);
      if (out_ready) void'(exp_q[id].pop_front());
      else if (stall_m[id] < smax) stall_m[id]++;
    end else begin
      chk("idle_inst", id, inst, NOP);
      chk("idle_pc", id, pc, 32'd0);
      chk("idle_pc4", id, pc4, 32'd0);
    end
    if (flush) exp_q[id].delete();
  endtask

  // Checkers sample 2 time units before each rising edge.
  initial forever begin
    @(negedge clk); #3;
    monitor(1, 1'b1, 15, if1.out_valid, if1.in_ready, if1.out_inst, if1.out_pc, if1.out_pc4, {12'd0, sc1});
  end

  initial forever begin
    @(negedge clk); #3;
    monitor(0, 1'b0, 65535, if0.out_valid, if0.in_ready, if0.out_inst, if0.out_pc, if0.out_pc4, sc0);
  end

  // Scoreboard producer: records every entry the upcoming edge will accept.
  initial forever begin
    @(negedge clk); #4;
    if (reset_n && !flush && in_valid) begin
      if (if1.in_ready) exp_q[1].push_back(entry_t'{inst: in_inst, pc: in_pc, pc4: in_pc4});
      if (if0.in_ready) exp_q[0].push_back(entry_t'{inst: in_inst, pc: in_pc, pc4: in_pc4});
    end
  end

  // Called at a falling edge; presents one entry until the SKID=1 instance takes it.
  task automatic send(input logic [31:0] inst, input logic [31:0] pc);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    in_pc4   = pc + 32'd4;
    for (int i = 0; i < 50 && !done; i++) begin
      #4;
      if (if1.in_ready) done = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (done) n_pass++;
    else $display("FAIL send_timeout pc=%h: got no accept expected accept within 50 cycles", pc);
    in_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Reset then stream
    out_ready = 1'b1;
    send(32'h0050_0093, 32'h0);
    send(32'h00A0_0113, 32'h4);
    repeat (3) @(negedge clk);

    // Backpressure, stall saturation, then release
    send(32'h0000_1093, 32'h0);
    out_ready = 1'b0;
    send(32'h0000_2093, 32'h4);
    in_valid = 1'b1; in_inst = 32'h0000_3093; in_pc = 32'h8; in_pc4 = 32'hC;
    repeat (20) @(negedge clk);
    out_ready = 1'b1;
    send(32'h0000_3093, 32'h8);
    send(32'h0000_4093, 32'hC);
    repeat (4) @(negedge clk);

    // Flush while FULL, incoming entry discarded
    out_ready = 1'b0;
    send(32'h0000_5093, 32'h10);
    send(32'h0000_6093, 32'h14);
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'h0000_7093; in_pc = 32'h18; in_pc4 = 32'h1C;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Asynchronous reset while holding one entry
    out_ready = 1'b0;
    send(32'h0000_8093, 32'h20);
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Toggling downstream ready with continuous input
    for (int i = 0; i < 24; i++) begin
      in_valid = 1'b1; in_inst = 32'h0010_0000 + 32'(i); in_pc = 32'h100 + 32'(i * 4); in_pc4 = in_pc + 32'd4;
      out_ready = i[0];
      @(negedge clk);
    end

    // Randomised traffic with occasional flushes
    for (int i = 0; i < 800; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_inst   = $urandom;
      in_pc     = $urandom & 32'hFFFF_FFFC;
      in_pc4    = in_pc + 32'd4;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      @(negedge clk);
    end

    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed IF/ID register: one elastic pipeline stage carrying instruction, PC and PC+4 between any two stages of the RISC-V pipeline.
- Adds valid/ready flow control, an optional 2-entry skid buffer (registered in_ready), synchronous flush with NOP injection, and a saturating stall-cycle counter for performance debug.

Parameters:
XLEN, 32, width of in_pc/in_pc4/out_pc/out_pc4
ILEN, 32, width of instruction field
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
NOP_INST, 32'h0000_0013, instruction value presented whenever the stage holds no valid entry (addi x0,x0,0)
CNT_W, 16, width of stall counter

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of all held and incoming entries
in_valid  input  1  upstream entry valid
in_ready  output  1  stage can accept an entry this cycle
in_inst  input  ILEN  upstream instruction
in_pc  input  XLEN  upstream PC
in_pc4  input  XLEN  upstream PC+4
out_valid  output  1  entry presented downstream
out_ready  input  1  downstream accepts
out_inst  output  ILEN  presented instruction (NOP_INST when !out_valid)
out_pc  output  XLEN  presented PC (0 when !out_valid)
out_pc4  output  XLEN  presented PC+4 (0 when !out_valid)
stall_cnt  output  CNT_W  count of cycles with out_valid && !out_ready

Behaviour:
- Single clock clk; reset_n asynchronous, active-low. While reset_n=0: out_valid=0, out_inst=NOP_INST, out_pc=0, out_pc4=0, skid empty, stall_cnt=0. in_ready=1 during and after reset (SKID=1: registered to 1 on reset).
- Accept: in_valid && in_ready at a rising edge. Deliver: out_valid && out_ready at a rising edge.
- Latency: an entry accepted into an empty stage appears on out_* the next cycle (1-cycle latency, as the fixed register).
- Payload stability: while out_valid && !out_ready, out_* must not change.
- Ordering: entries leave in acceptance order; no drop, no duplication except via flush.
- SKID=0: in_ready = !out_valid || out_ready (combinational). On accept, main register loads input; on deliver without accept, out_valid clears.
- SKID=1 states (main, skid): EMPTY(0,0), ONE(1,0), FULL(1,1).
  - EMPTY: accept -> ONE.
  - ONE: accept && deliver -> ONE (main reloads); accept && !deliver -> FULL (input into skid); deliver only -> EMPTY.
  - FULL: in_ready=0; deliver -> ONE (skid moves to main); no deliver -> FULL.
  - in_ready = !skid_valid, from a flop, no combinational path from out_ready.
- Flush (highest priority, synchronous): next edge -> EMPTY; main payload forced to NOP_INST/0/0; any entry accepted in the flush cycle is discarded. in_ready may be 1 during flush (acceptance is harmless). Flush in reset ignored.
- Invalid presentation: whenever out_valid=0, out_inst=NOP_INST and out_pc/out_pc4=0 (register-held, not muxed from skid).
- stall_cnt: +1 per cycle with out_valid && !out_ready; saturates at 2^CNT_W-1; unaffected by flush; cleared only by reset.
- Reset mid-operation: all entries lost immediately (asynchronous), outputs take reset values within the same cycle.

Test Plan:
- Reset then stream: reset_n low 3 cycles, release, in_valid=1 with inst 0x00500093/pc 0x0/pc4 0x4, then 0x00A00113/0x4/0x8, out_ready=1 -> out_valid rises one cycle after each accept, payloads in order, out_inst=0x00000013 before first.
- Backpressure (SKID=1): stream 4 entries pc 0x0,0x4,0x8,0xC with out_ready=0 from cycle 2 -> in_ready falls after 2 accepts, out_pc holds 0x0, stall_cnt increments each cycle; release out_ready -> 0x0,0x4,0x8,0xC delivered with no gaps or duplicates.
- Flush while FULL: FULL with pc 0x10,0x14, assert flush 1 cycle with in_valid=1 pc 0x18 -> next cycle out_valid=0, out_inst=0x00000013, out_pc=0, in_ready=1; 0x18 never appears.
- SKID=0 instance: out_ready toggling 1/0 each cycle, continuous input -> in_ready equals !out_valid||out_ready combinationally, full throughput when out_ready=1.
- Stall counter saturation (CNT_W=4): hold out_valid with out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays; flush leaves it at 15; reset_n low clears to 0.
- Async reset mid-stream: drop reset_n between clock edges while ONE -> out_valid=0 and out_inst=0x00000013 before the next rising edge.
